// File: rtl/frame_align.sv
// Frame-clock alignment controller: issues ISERDES bitslips until the frame word
// matches FRAME_PATTERN. Optional realign statistics via `FRAME_ALIGN_STATS_EN`.
module frame_align #(
  parameter int unsigned              FRAME_WIDTH   = 8,
  parameter logic [FRAME_WIDTH-1:0]   FRAME_PATTERN = 8'hF0,
  parameter int unsigned              SETTLE_CYCLES = 4,
  parameter int unsigned              MATCH_COUNT   = 16,
  parameter int unsigned              LOSS_COUNT    = 4,
  parameter int unsigned              MAX_SLIPS     = 8
) (
  input  logic                   adc_clock,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   mmcm_locked,
  input  logic [FRAME_WIDTH-1:0] frame_data,
  output logic                   bitslip,
  output logic [3:0]             bitslip_count,
  output logic                   clk_align_frame_valid,
  output logic                   align_error,
  output logic [15:0]            realign_count
);

  localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_CHECK     = 3'd3,
    S_SLIP      = 3'd4,
    S_LOCKED    = 3'd5,
    S_FAIL      = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic [3:0]         slips_q, slips_d;
  logic               bitslip_q, bitslip_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               frame_match_c;

  assign frame_match_c = (frame_data == FRAME_PATTERN);

  // Next-state logic; enable and MMCM lock override every state.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    loss_d    = loss_q;
    slips_d   = slips_q;
    bitslip_d = 1'b0;
    valid_d   = valid_q;
    error_d   = error_q;

    if (!enable) begin
      state_d  = S_IDLE;
      settle_d = '0;
      match_d  = '0;
      loss_d   = '0;
      slips_d  = '0;
      valid_d  = 1'b0;
      error_d  = 1'b0;
    end else if (!mmcm_locked && (state_q != S_IDLE) && (state_q != S_WAIT_LOCK)) begin
      // ISERDES is reset together with the MMCM, so the slip history is void.
      state_d  = S_WAIT_LOCK;
      settle_d = '0;
      match_d  = '0;
      loss_d   = '0;
      slips_d  = '0;
      valid_d  = 1'b0;
      error_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          error_d = 1'b0;
          slips_d = '0;
          state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (mmcm_locked) begin
            state_d  = S_SETTLE;
            settle_d = SET_W'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            state_d = S_CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
        S_CHECK: begin
          if (frame_match_c) begin
            if (match_q == MATCH_W'(MATCH_COUNT - 1)) begin
              state_d = S_LOCKED;
              valid_d = 1'b1;
              loss_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else if (slips_q < 4'(MAX_SLIPS - 1)) begin
            state_d   = S_SLIP;
            bitslip_d = 1'b1;
            slips_d   = slips_q + 4'd1;
          end else begin
            state_d = S_FAIL;
            error_d = 1'b1;
          end
        end
        S_SLIP: begin
          state_d  = S_SETTLE;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
        end
        S_LOCKED: begin
          if (frame_match_c) begin
            loss_d = '0;
          end else if (loss_q == LOSS_W'(LOSS_COUNT - 1)) begin
            state_d = S_CHECK;
            valid_d = 1'b0;
            loss_d  = '0;
            match_d = '0;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
        S_FAIL: begin
          error_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      match_q   <= '0;
      loss_q    <= '0;
      slips_q   <= '0;
      bitslip_q <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      loss_q    <= loss_d;
      slips_q   <= slips_d;
      bitslip_q <= bitslip_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign bitslip               = bitslip_q;
  assign bitslip_count         = slips_q;
  assign clk_align_frame_valid = valid_q;
  assign align_error           = error_q;

`ifdef FRAME_ALIGN_STATS_EN
  logic [15:0] realign_q;
  logic        loss_evt_c;

  // Same condition as the LOCKED-to-CHECK transition above, with overrides excluded.
  assign loss_evt_c = enable && mmcm_locked && (state_q == S_LOCKED) && !frame_match_c &&
                      (loss_q == LOSS_W'(LOSS_COUNT - 1));

  always_ff @(posedge adc_clock or negedge rst_n) begin
    if (!rst_n) begin
      realign_q <= '0;
    end else if (!enable) begin
      realign_q <= '0;
    end else if (loss_evt_c && (realign_q != 16'hFFFF)) begin
      realign_q <= realign_q + 16'd1;
    end
  end

  assign realign_count = realign_q;
`else
  assign realign_count = 16'd0;
`endif

endmodule

// File: tb/tb_frame_align.sv
// Directed bench for frame_align with a rotate-left ISERDES model driven by bitslip.
module tb_frame_align;

  logic        adc_clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mmcm_locked;
  logic [7:0]  frame_data;
  logic        bitslip;
  logic [3:0]  bitslip_count;
  logic        clk_align_frame_valid;
  logic        align_error;
  logic [15:0] realign_count;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse = -1000;
  int min_gap = 1000;
  logic iserdes_en = 1'b0;

  frame_align dut (
    .adc_clock             (adc_clock),
    .rst_n                 (rst_n),
    .enable                (enable),
    .mmcm_locked           (mmcm_locked),
    .frame_data            (frame_data),
    .bitslip               (bitslip),
    .bitslip_count         (bitslip_count),
    .clk_align_frame_valid (clk_align_frame_valid),
    .align_error           (align_error),
    .realign_count         (realign_count)
  );

  always #5 adc_clock = ~adc_clock;

`ifdef FRAME_ALIGN_STATS_EN
  localparam logic [15:0] EXP_REALIGN = 16'd1;
`else
  localparam logic [15:0] EXP_REALIGN = 16'd0;
`endif

  // Advance one cycle, sample 1 time unit after the edge, track bitslip pulses.
  task automatic tick();
    @(posedge adc_clock);
    #1;
    cyc++;
    if (bitslip === 1'b1) begin
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      pulse_cnt++;
      if (iserdes_en) frame_data = {frame_data[6:0], frame_data[7]};
    end
  endtask

  task automatic clear_pulse_stats();
    pulse_cnt  = 0;
    last_pulse = -1000;
    min_gap    = 1000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mmcm_locked = 1'b0; frame_data = 8'h00;
    tick(); tick();
    checks++;
    if ({bitslip, bitslip_count, clk_align_frame_valid, align_error, realign_count} !== 23'd0)
      $display("FAIL reset_outputs: got %b, want all zero",
               {bitslip, bitslip_count, clk_align_frame_valid, align_error, realign_count});
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_aligned_start();
    bit v21, v22;
    frame_data = 8'hF0; mmcm_locked = 1'b1; iserdes_en = 1'b0;
    clear_pulse_stats();
    enable = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 21) v21 = clk_align_frame_valid;
      if (k == 22) v22 = clk_align_frame_valid;
    end
    checks++;
    if (v21 !== 1'b0) $display("FAIL aligned_valid_early: got %b at edge 21, want 0", v21);
    else passed++;
    checks++;
    if (v22 !== 1'b1) $display("FAIL aligned_valid_latency: got %b at edge 22, want 1", v22);
    else passed++;
    checks++;
    if (pulse_cnt !== 0 || bitslip_count !== 4'd0)
      $display("FAIL aligned_no_slip: got pulses=%0d count=%0d, want 0/0", pulse_cnt, bitslip_count);
    else passed++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    frame_data = 8'h1E; iserdes_en = 1'b1; mmcm_locked = 1'b1;
    clear_pulse_stats();
    enable = 1'b1;
    for (int i = 0; i < 200 && clk_align_frame_valid !== 1'b1; i++) tick();
    checks++;
    if (clk_align_frame_valid !== 1'b1) $display("FAIL misalign_lock: got valid=%b, want 1", clk_align_frame_valid);
    else passed++;
    checks++;
    if (pulse_cnt !== 3 || bitslip_count !== 4'd3)
      $display("FAIL misalign_slips: got pulses=%0d count=%0d, want 3/3", pulse_cnt, bitslip_count);
    else passed++;
    checks++;
    if (min_gap < 6) $display("FAIL misalign_spacing: got min gap %0d, want >= 6", min_gap);
    else passed++;
  endtask

  task automatic test_loss_locked();
    bit held;
    iserdes_en = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame_data = (i < 3) ? 8'h00 : 8'hF0;
      tick();
      if (clk_align_frame_valid !== 1'b1) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) $display("FAIL loss_glitch: got valid dropped, want held at 1");
    else passed++;
    frame_data = 8'h00;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (clk_align_frame_valid !== 1'b1) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) $display("FAIL loss_early: got valid dropped before 4th bad word, want 1");
    else passed++;
    tick();
    checks++;
    if (clk_align_frame_valid !== 1'b0) $display("FAIL loss_valid: got %b on 4th bad edge, want 0", clk_align_frame_valid);
    else passed++;
    checks++;
    if (realign_count !== EXP_REALIGN) $display("FAIL loss_realign: got %0d, want %0d", realign_count, EXP_REALIGN);
    else passed++;
    tick();
    checks++;
    if (bitslip !== 1'b1 || bitslip_count !== 4'd4)
      $display("FAIL loss_recheck: got bitslip=%b count=%0d, want 1/4", bitslip, bitslip_count);
    else passed++;
    enable = 1'b0;
    tick();
    checks++;
    if ({bitslip, bitslip_count, clk_align_frame_valid, align_error, realign_count} !== 23'd0)
      $display("FAIL loss_disable: got %b, want all zero",
               {bitslip, bitslip_count, clk_align_frame_valid, align_error, realign_count});
    else passed++;
  endtask

  task automatic test_never_match();
    int p;
    frame_data = 8'hAA; iserdes_en = 1'b1; mmcm_locked = 1'b1;
    clear_pulse_stats();
    enable = 1'b1;
    for (int i = 0; i < 300 && align_error !== 1'b1; i++) tick();
    checks++;
    if (align_error !== 1'b1 || bitslip_count !== 4'd7 || clk_align_frame_valid !== 1'b0)
      $display("FAIL never_fail_state: got err=%b count=%0d valid=%b, want 1/7/0",
               align_error, bitslip_count, clk_align_frame_valid);
    else passed++;
    p = pulse_cnt;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (p !== 7 || pulse_cnt !== 7 || min_gap < 6)
      $display("FAIL never_pulses: got %0d then %0d (gap %0d), want 7/7 gap>=6", p, pulse_cnt, min_gap);
    else passed++;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    checks++;
    if ({bitslip, bitslip_count, clk_align_frame_valid, align_error} !== 7'd0)
      $display("FAIL never_disable: got %b, want all zero",
               {bitslip, bitslip_count, clk_align_frame_valid, align_error});
    else passed++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_mmcm_drop();
    bit quiet;
    bit v20, v21;
    frame_data = 8'hAA; iserdes_en = 1'b1; mmcm_locked = 1'b1;
    clear_pulse_stats();
    enable = 1'b1;
    for (int i = 0; i < 100 && pulse_cnt < 2; i++) tick();
    tick(); tick();
    checks++;
    if (bitslip_count !== 4'd2) $display("FAIL drop_setup: got count=%0d, want 2", bitslip_count);
    else passed++;
    mmcm_locked = 1'b0;
    tick();
    checks++;
    if (bitslip_count !== 4'd0 || bitslip !== 1'b0)
      $display("FAIL drop_clear: got count=%0d bitslip=%b, want 0/0", bitslip_count, bitslip);
    else passed++;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bitslip !== 1'b0 || bitslip_count !== 4'd0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) $display("FAIL drop_hold: got activity while unlocked, want idle");
    else passed++;
    frame_data = 8'hF0; iserdes_en = 1'b0; mmcm_locked = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 20) v20 = clk_align_frame_valid;
      if (k == 21) v21 = clk_align_frame_valid;
    end
    checks++;
    if (v20 !== 1'b0 || v21 !== 1'b1 || bitslip_count !== 4'd0)
      $display("FAIL drop_relock: got v20=%b v21=%b count=%0d, want 0/1/0", v20, v21, bitslip_count);
    else passed++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit v21, v22;
    frame_data = 8'hAA; iserdes_en = 1'b1; mmcm_locked = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 100 && bitslip !== 1'b1; i++) tick();
    checks++;
    if (bitslip !== 1'b1) $display("FAIL async_setup: got bitslip=%b, want 1", bitslip);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bitslip, bitslip_count, clk_align_frame_valid, align_error, realign_count} !== 23'd0)
      $display("FAIL async_clear: got %b, want all zero without clock",
               {bitslip, bitslip_count, clk_align_frame_valid, align_error, realign_count});
    else passed++;
    enable = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    frame_data = 8'hF0; iserdes_en = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 21) v21 = clk_align_frame_valid;
      if (k == 22) v22 = clk_align_frame_valid;
    end
    checks++;
    if (v21 !== 1'b0 || v22 !== 1'b1)
      $display("FAIL async_restart: got v21=%b v22=%b, want 0/1 (restart from idle)", v21, v22);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_aligned_start();
    test_misaligned();
    test_loss_locked();
    test_never_match();
    test_mmcm_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
